// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encodings and
// drain-length default.
package pipeline_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_STEP_IDLE = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_HALTED    = 3'd3
  } seq_state_t;

  localparam int unsigned DRAIN_CYCLES_DEFAULT = 4;
  localparam logic [15:0] STALL_COUNT_MAX      = 16'hFFFF;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the pipeline datapath (master) and the
// sequencer (slave): hazard inputs, debug controls and pipeline enables.
interface pipeline_sequencer_if;

  logic [4:0]  i_ID_rs;
  logic [4:0]  i_ID_rt;
  logic        i_ID_UsesRt;
  logic        i_ID_Halt;
  logic        i_EX_MemRead;
  logic [4:0]  i_EX_rt;
  logic        i_Step_Mode;
  logic        i_Step;
  logic        i_Resume;
  logic        o_PC_Write;
  logic        o_IF_ID_Write;
  logic        o_ID_EX_Stall;
  logic        o_Halted;
  logic [2:0]  o_State;
  logic [15:0] o_Stall_Count;

  modport master (
    output i_ID_rs, i_ID_rt, i_ID_UsesRt, i_ID_Halt, i_EX_MemRead, i_EX_rt,
           i_Step_Mode, i_Step, i_Resume,
    input  o_PC_Write, o_IF_ID_Write, o_ID_EX_Stall, o_Halted, o_State,
           o_Stall_Count
  );

  modport slave (
    input  i_ID_rs, i_ID_rt, i_ID_UsesRt, i_ID_Halt, i_EX_MemRead, i_EX_rt,
           i_Step_Mode, i_Step, i_Resume,
    output o_PC_Write, o_IF_ID_Write, o_ID_EX_Stall, o_Halted, o_State,
           o_Stall_Count
  );

endinterface

// File: rtl/pipeline_sequencer_load_use_detect.sv
// Load-use hazard comparator: a load in ID/EX whose destination feeds a
// source of the instruction in ID. Register 0 never creates a hazard.
module load_use_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       hazard
);

  // Pure combinational compare, no added latency
  always_comb begin
    hazard = ex_mem_read && (ex_rt != '0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: load-use stalling, HALT drain, debug single-step,
// and a saturating load-use bubble counter.
import pipeline_sequencer_pkg::*;

module pipeline_sequencer #(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  pipeline_sequencer_if.slave bus
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  seq_state_t  state, state_next;
  logic [3:0]  drain_cnt, drain_next;
  logic        pending, pending_next;
  logic [15:0] stall_count;
  logic        hazard;
  logic        pc_write, if_id_write, id_ex_stall, count_bubble;

  load_use_detect u_load_use_detect (
    .ex_mem_read (bus.i_EX_MemRead),
    .ex_rt       (bus.i_EX_rt),
    .id_rs       (bus.i_ID_rs),
    .id_rt       (bus.i_ID_rt),
    .id_uses_rt  (bus.i_ID_UsesRt),
    .hazard      (hazard)
  );

  // State, drain counter, pending flag and bubble counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      drain_cnt   <= '0;
      pending     <= 1'b0;
      stall_count <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
      pending   <= pending_next;
      if (count_bubble && (stall_count != STALL_COUNT_MAX))
        stall_count <= stall_count + 16'd1;
    end
  end

  // Next-state and pipeline-enable decode; default is a bubble cycle
  always_comb begin
    state_next   = state;
    drain_next   = drain_cnt;
    pending_next = pending;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_stall  = 1'b1;
    count_bubble = 1'b0;
    case (state)
      ST_RUN: begin
        if (hazard) begin
          count_bubble = 1'b1;
        end else if (bus.i_ID_Halt) begin
          id_ex_stall = 1'b0;
          state_next  = ST_DRAIN;
          drain_next  = DRAIN_LOAD;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          id_ex_stall = 1'b0;
          state_next  = bus.i_Step_Mode ? ST_STEP_IDLE : ST_RUN;
        end
      end
      ST_STEP_IDLE: begin
        if (!bus.i_Step_Mode) begin
          state_next   = ST_RUN;
          pending_next = 1'b0;
        end else if (bus.i_Step || pending) begin
          // A step that collides with a hazard is held in the pending
          // flag and granted on the first hazard-free cycle
          if (hazard) begin
            count_bubble = 1'b1;
            pending_next = 1'b1;
          end else if (bus.i_ID_Halt) begin
            id_ex_stall  = 1'b0;
            state_next   = ST_DRAIN;
            drain_next   = DRAIN_LOAD;
            pending_next = 1'b0;
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_stall  = 1'b0;
            pending_next = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt <= 4'd1) begin
          drain_next = '0;
          state_next = ST_HALTED;
        end else begin
          drain_next = drain_cnt - 4'd1;
        end
      end
      ST_HALTED: begin
        if (bus.i_Resume)
          state_next = bus.i_Step_Mode ? ST_STEP_IDLE : ST_RUN;
      end
      default: begin
        state_next   = ST_RUN;
        drain_next   = '0;
        pending_next = 1'b0;
      end
    endcase
  end

  // Reset overrides the decoded enables without waiting for a clock
  always_comb begin
    bus.o_PC_Write    = pc_write & ~rst;
    bus.o_IF_ID_Write = if_id_write & ~rst;
    bus.o_ID_EX_Stall = id_ex_stall | rst;
    bus.o_Halted      = (state == ST_HALTED);
    bus.o_State       = state;
    bus.o_Stall_Count = stall_count;
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: hazard stalls, HALT drain,
// single-step, counter saturation and asynchronous reset.
module tb_pipeline_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  pipeline_sequencer_if bus ();

  pipeline_sequencer #(.DRAIN_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt);
    bus.i_EX_MemRead = mr;
    bus.i_EX_rt      = ert;
    bus.i_ID_rs      = rs;
    bus.i_ID_rt      = rt;
    bus.i_ID_UsesRt  = urt;
    #1;
  endtask

  // Checks PC_Write, IF_ID_Write and ID_EX_Stall together
  task automatic chk_en(input string tag, input logic pc, input logic ifid, input logic st);
    chk({tag, "_pc"}, 32'(bus.o_PC_Write), 32'(pc));
    chk({tag, "_ifid"}, 32'(bus.o_IF_ID_Write), 32'(ifid));
    chk({tag, "_stall"}, 32'(bus.o_ID_EX_Stall), 32'(st));
  endtask

  initial begin
    bus.i_ID_Halt   = 1'b0;
    bus.i_Step_Mode = 1'b0;
    bus.i_Step      = 1'b0;
    bus.i_Resume    = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // Reset values
    chk_en("rst", 1'b0, 1'b0, 1'b1);
    chk("rst_state", 32'(bus.o_State), 32'd0);
    chk("rst_halted", 32'(bus.o_Halted), 32'd0);
    chk("rst_count", 32'(bus.o_Stall_Count), 32'd0);
    tick();
    rst = 1'b0;

    // Load to r0 never stalls
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    chk_en("r0", 1'b1, 1'b1, 1'b0);
    tick();
    chk("r0_count", 32'(bus.o_Stall_Count), 32'd0);

    // Load rt=5, ID rs=5: bubble, count 0 -> 1
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    chk_en("rs_haz", 1'b0, 1'b0, 1'b1);
    tick();
    chk("rs_haz_count", 32'(bus.o_Stall_Count), 32'd1);
    chk("rs_haz_state", 32'(bus.o_State), 32'd0);

    // Match via rt only when rt is a source
    set_in(1'b1, 5'd7, 5'd3, 5'd7, 1'b1);
    chk_en("rt_haz", 1'b0, 1'b0, 1'b1);
    tick();
    chk("rt_haz_count", 32'(bus.o_Stall_Count), 32'd2);
    set_in(1'b1, 5'd7, 5'd3, 5'd7, 1'b0);
    chk_en("rt_unused", 1'b1, 1'b1, 1'b0);
    set_in(1'b0, 5'd5, 5'd5, 5'd5, 1'b1);
    chk_en("no_load", 1'b1, 1'b1, 1'b0);
    tick();
    chk("no_load_count", 32'(bus.o_Stall_Count), 32'd2);

    // HALT: pass-through, 4 drain cycles, halted
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    bus.i_ID_Halt = 1'b1;
    #1;
    chk_en("halt_pass", 1'b0, 1'b0, 1'b0);
    tick();
    bus.i_ID_Halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_state", 32'(bus.o_State), 32'd2);
      chk_en("drain", 1'b0, 1'b0, 1'b1);
      chk("drain_halted", 32'(bus.o_Halted), 32'd0);
      tick();
    end
    chk("halted_state", 32'(bus.o_State), 32'd3);
    chk("halted_flag", 32'(bus.o_Halted), 32'd1);
    chk_en("halted", 1'b0, 1'b0, 1'b1);
    // Hazard and step ignored while halted
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    bus.i_Step = 1'b1;
    tick();
    bus.i_Step = 1'b0;
    chk("halted_hold", 32'(bus.o_State), 32'd3);
    chk("halted_count", 32'(bus.o_Stall_Count), 32'd2);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    bus.i_Resume = 1'b1;
    tick();
    chk("resume_state", 32'(bus.o_State), 32'd0);
    chk("resume_halted", 32'(bus.o_Halted), 32'd0);
    // Resume outside HALTED does nothing
    tick();
    chk("resume_run", 32'(bus.o_State), 32'd0);
    bus.i_Resume = 1'b0;

    // Single step with a hazard on the step pulse
    bus.i_Step_Mode = 1'b1;
    #1;
    tick();
    chk("step_idle", 32'(bus.o_State), 32'd1);
    chk_en("step_wait", 1'b0, 1'b0, 1'b1);
    set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
    bus.i_Step = 1'b1;
    #1;
    chk_en("step_haz", 1'b0, 1'b0, 1'b1);
    tick();
    bus.i_Step = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("step_haz_state", 32'(bus.o_State), 32'd1);
    chk_en("step_grant", 1'b1, 1'b1, 1'b0);
    tick();
    chk("step_back", 32'(bus.o_State), 32'd1);
    chk_en("step_done", 1'b0, 1'b0, 1'b1);
    tick();
    chk_en("step_nopend", 1'b0, 1'b0, 1'b1);
    bus.i_Step_Mode = 1'b0;
    tick();
    chk("step_exit", 32'(bus.o_State), 32'd0);

    // Asynchronous reset in DRAIN with counter at 2
    bus.i_ID_Halt = 1'b1;
    tick();
    bus.i_ID_Halt = 1'b0;
    tick();
    tick();
    chk("pre_rst_state", 32'(bus.o_State), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk_en("async_rst", 1'b0, 1'b0, 1'b1);
    chk("async_rst_state", 32'(bus.o_State), 32'd0);
    chk("async_rst_count", 32'(bus.o_Stall_Count), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_state", 32'(bus.o_State), 32'd0);
    chk("post_rst_halted", 32'(bus.o_Halted), 32'd0);
    chk_en("post_rst", 1'b1, 1'b1, 1'b0);

    // Saturation: 65534 bubbles reach 0xFFFE, then 3 more hold 0xFFFF
    set_in(1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", 32'(bus.o_Stall_Count), 32'h0000FFFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_ffff", 32'(bus.o_Stall_Count), 32'h0000FFFF);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter DRAIN_CYCLES, default 4; number of bubble cycles issued after a halt enters ID/EX, before the core reports halted; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 i_ID_rs / i_ID_rt  in  5 each  source register fields of the instruction currently in ID.
REQ-005 i_ID_UsesRt  in  1  the ID instruction reads rt as a source.
REQ-006 i_ID_Halt  in  1  the ID instruction is HALT.
REQ-007 i_EX_MemRead / i_EX_rt  in  1 / 5  load flag and load destination currently held in ID/EX.
REQ-008 i_Step_Mode / i_Step / i_Resume  in  1 each  debug single-step enable, one-cycle step pulse, and release from HALTED.
REQ-009 o_PC_Write / o_IF_ID_Write  out  1 each  PC update enable and IF/ID load enable.
REQ-010 o_ID_EX_Stall  out  1  drives the ID/EX stall (NOP-injection) input.
REQ-011 o_Halted  out  1  pipeline drained after HALT.
REQ-012 o_State  out  3  current FSM state encoding.
REQ-013 o_Stall_Count  out  16  count of load-use bubbles.

Function
REQ-014 States: RUN=0, STEP_IDLE=1, DRAIN=2, HALTED=3; other encodings SHALL recover to RUN on the next edge.
REQ-015 hazard = i_EX_MemRead AND i_EX_rt!=0 AND (i_EX_rt==i_ID_rs OR (i_ID_UsesRt AND i_EX_rt==i_ID_rt)); combinational, no added latency.
REQ-016 RUN, hazard=1: PC_Write=0, IF_ID_Write=0, ID_EX_Stall=1 in the same cycle; state is unchanged. Hazard has priority over halt and step.
REQ-017 RUN, no hazard, i_ID_Halt=0: PC_Write=1, IF_ID_Write=1, ID_EX_Stall=0. Next state is STEP_IDLE if i_Step_Mode=1, otherwise RUN.
REQ-018 RUN or step grant, no hazard, i_ID_Halt=1: PC_Write=0, IF_ID_Write=0, ID_EX_Stall=0, so the HALT passes into ID/EX. Next state is DRAIN and drain counter = DRAIN_CYCLES.
REQ-019 STEP_IDLE: PC_Write=0, IF_ID_Write=0, ID_EX_Stall=1 unless a step is granted. Step pending = i_Step OR a latched pending flag.
REQ-020 STEP_IDLE, step pending, no hazard: outputs as in REQ-017 (or REQ-018 if i_ID_Halt=1) for exactly one cycle. The pending flag is cleared.
REQ-021 STEP_IDLE, step pending, hazard: a bubble is issued per REQ-016. The pending flag is set, and the step is granted on the first hazard-free cycle.
REQ-022 STEP_IDLE with i_Step_Mode=0 returns to RUN on the next edge; the pending flag is cleared.
REQ-023 DRAIN: PC_Write=0, IF_ID_Write=0, ID_EX_Stall=1. The counter decrements each cycle; at counter==1 the next state is HALTED.
REQ-024 HALTED: outputs as in DRAIN, with o_Halted=1. i_Resume=1 moves to STEP_IDLE if i_Step_Mode=1, otherwise to RUN. Hazard and step inputs are ignored.
REQ-025 o_Stall_Count increments by 1 on each cycle where REQ-016 applies. It saturates at 0xFFFF and does not wrap. DRAIN and STEP_IDLE bubbles are not counted.
REQ-026 i_Resume in any state other than HALTED has no effect.

Reset
REQ-027 rst=1 SHALL immediately force: state RUN, drain counter 0, pending flag 0, o_Stall_Count 0, o_Halted 0.
REQ-028 During reset, PC_Write=0, IF_ID_Write=0, ID_EX_Stall=1.
REQ-029 Reset asserted mid-DRAIN or mid-step SHALL abandon the operation; after release the block starts in RUN.

Structure
REQ-030 State encodings and the DRAIN_CYCLES default SHALL live in the shared mips package.
REQ-031 The hazard comparator SHALL be a sub-module, load_use_detect (purely combinational); FSM, counters and pending flag stay in pipeline_sequencer.

Verification
REQ-032 EX load to rt=5 with ID rs=5: hazard=1, bubble cycle with PC_Write=0 and ID_EX_Stall=1; o_Stall_Count 0 -> 1.
REQ-033 EX load to rt=0 with ID rs=0: no stall; PC_Write=1.
REQ-034 i_ID_Halt in RUN: one pass-through cycle (ID_EX_Stall=0), then 4 DRAIN cycles, then o_Halted=1 and o_State=3. i_Resume -> RUN the next cycle.
REQ-035 Step mode, i_Step pulse coinciding with a hazard: one bubble, then one granted advance cycle, then return to STEP_IDLE with pending=0.
REQ-036 Force o_Stall_Count to 0xFFFE, then apply 3 hazard cycles: count holds at 0xFFFF.
REQ-037 Assert rst asynchronously mid-DRAIN (counter=2): outputs switch immediately to reset values; after release state is RUN and o_Halted=0.
